// File: rtl/spi_pkg.sv
// Shared definitions for the SCRATCH SPI link: FSM encoding, line polarities
// and the bit-counter sizing helper.
`default_nettype none

package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'b00,
    IDLE      = 2'b01,
    SHIFT     = 2'b10
  } state_t;

  localparam logic CS_ACTIVE    = 1'b0;
  localparam logic EDGE_FALLING = 1'b0;
  localparam logic EDGE_RISING  = 1'b1;

  // Counter must reach DATASIZE+1 so that an overrun is distinguishable.
  function automatic int cnt_width(input int datasize);
    return $clog2(datasize + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// Single-bit multi-stage synchronizer with asynchronous reset to a chosen level.
`default_nettype none

module sync_ff #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {SYNC_STAGES{RESET_VAL}};
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_receive_scratch.sv
// SPI slave deserializer: oversamples SCLK/MOSI/CS, shifts MSB-first frames on
// the selected SCLK edge and strobes each complete word out.
`default_nettype none

module spi_receive_scratch
  import spi_pkg::*;
#(
  parameter int DATASIZE    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Enable,
  input  logic                i_EdgeShape,
  input  logic                i_SCLK,
  input  logic                i_MOSI,
  input  logic                i_CS,
  output logic [DATASIZE-1:0] o_Data,
  output logic                o_Valid,
  output logic                o_Busy,
  output logic                o_FrameError
);

  localparam int            CW       = cnt_width(DATASIZE);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATASIZE);
  localparam logic [CW-1:0] CNT_OVR  = CW'(DATASIZE + 1);

  logic sclk_s, mosi_s, cs_s;
  logic sclk_d, cs_d;
  logic [SYNC_STAGES-1:0] fill;
  logic settled;

  state_t              state;
  logic [DATASIZE-1:0] shift;
  logic [CW-1:0]       count;

  logic                sclk_rise, sclk_fall, cs_rise, cs_fall, sample_edge;
  logic [DATASIZE-1:0] shift_next, shift_final;
  logic [CW-1:0]       count_next, count_final;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(i_Clk), .rst(i_Rst), .d(i_SCLK), .q(sclk_s)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(i_Clk), .rst(i_Rst), .d(i_MOSI), .q(mosi_s)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(i_Clk), .rst(i_Rst), .d(i_CS), .q(cs_s)
  );

  // The CS chain shows its reset value until refilled; WAIT_IDLE must not trust it before then.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
      fill   <= '0;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
      fill   <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign settled     = fill[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign cs_rise     = cs_s & ~cs_d;
  assign cs_fall     = ~cs_s & cs_d;
  assign sample_edge = (i_EdgeShape == EDGE_RISING) ? sclk_rise : sclk_fall;

  assign shift_next  = {shift[DATASIZE-2:0], mosi_s};
  assign count_next  = (count == CNT_OVR) ? count : count + CW'(1);
  // A sampling edge coinciding with CS rising is part of the frame.
  assign shift_final = sample_edge ? shift_next : shift;
  assign count_final = sample_edge ? count_next : count;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= WAIT_IDLE;
      shift        <= '0;
      count        <= '0;
      o_Data       <= '0;
      o_Valid      <= 1'b0;
      o_Busy       <= 1'b0;
      o_FrameError <= 1'b0;
    end else begin
      o_Valid      <= 1'b0;
      o_FrameError <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (settled && cs_s != CS_ACTIVE) state <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            if (i_Enable) begin
              shift  <= '0;
              count  <= '0;
              o_Busy <= 1'b1;
              state  <= SHIFT;
            end else begin
              state <= WAIT_IDLE;
            end
          end
        end
        SHIFT: begin
          shift <= shift_final;
          count <= count_final;
          if (cs_rise) begin
            o_Busy <= 1'b0;
            state  <= IDLE;
            if (count_final == CNT_FULL) begin
              o_Data  <= shift_final;
              o_Valid <= 1'b1;
            end else begin
              o_FrameError <= 1'b1;
            end
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_receive_scratch.sv
// Directed bench for spi_receive_scratch: table of frames plus reset/disable/back-to-back sequences.
`default_nettype none

module tb_spi_receive_scratch;

  localparam int DATASIZE = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b1;
  logic                eshape = 1'b0;
  logic                sclk = 1'b0;
  logic                mosi = 1'b0;
  logic                cs = 1'b1;
  logic [DATASIZE-1:0] data;
  logic                valid, busy, ferr;

  spi_receive_scratch #(.DATASIZE(DATASIZE), .SYNC_STAGES(2)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_EdgeShape(eshape),
    .i_SCLK(sclk), .i_MOSI(mosi), .i_CS(cs),
    .o_Data(data), .o_Valid(valid), .o_Busy(busy), .o_FrameError(ferr)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic [DATASIZE-1:0] got_q[$];
  logic busy_mid;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      got_q.push_back(data);
    end
    if (ferr) err_cnt++;
    if (valid && ferr) both_cnt++;
  end

  typedef struct {
    logic [31:0]         val;
    int                  nbits;
    bit                  rw;      // 1: data changes just after SCLK falls, CS rises with SCLK high
    logic                esel;
    int                  exp_v;
    int                  exp_e;
    logic [DATASIZE-1:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bits(input logic [31:0] v, input int n, input bit rw);
    for (int i = n - 1; i >= 0; i--) begin
      if (!rw) begin
        mosi = v[i]; tick(1);
        sclk = 1'b1; tick(2);
        sclk = 1'b0; tick(1);
      end else begin
        sclk = 1'b0; tick(1);
        mosi = v[i]; tick(1);
        sclk = 1'b1; tick(2);
      end
      if (i == n / 2) busy_mid = busy;
    end
  endtask

  task automatic frame(input logic [31:0] v, input int n, input bit rw);
    cs = 1'b0; tick(3);
    bits(v, n, rw);
    tick(2);
    cs = 1'b1; tick(2);
    sclk = 1'b0;
  endtask

  int v0, e0;

  initial begin
    vecs[0] = '{32'h4BCA,  16, 1'b0, 1'b0, 1, 0, 16'h4BCA};
    vecs[1] = '{32'hA5C3,  16, 1'b1, 1'b1, 1, 0, 16'hA5C3};
    vecs[2] = '{32'hA5C3,  16, 1'b1, 1'b0, 0, 1, 16'hA5C3}; // only 15 falling edges inside CS
    vecs[3] = '{32'h0ABC,  12, 1'b0, 1'b0, 0, 1, 16'hA5C3};
    vecs[4] = '{32'h2AAAA, 18, 1'b0, 1'b0, 0, 1, 16'hA5C3};
    vecs[5] = '{32'h8001,  16, 1'b0, 1'b1, 1, 0, 16'h8001};

    tick(3);
    chk("reset_data", 32'(data), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_ferr", 32'(ferr), 32'h0);
    rst = 1'b0;
    tick(10);

    for (int k = 0; k < 6; k++) begin
      eshape = vecs[k].esel;
      tick(2);
      v0 = valid_cnt; e0 = err_cnt;
      frame(vecs[k].val, vecs[k].nbits, vecs[k].rw);
      tick(10);
      chk($sformatf("vec%0d_valid", k), 32'(valid_cnt - v0), 32'(vecs[k].exp_v));
      chk($sformatf("vec%0d_ferr", k), 32'(err_cnt - e0), 32'(vecs[k].exp_e));
      chk($sformatf("vec%0d_data", k), 32'(data), 32'(vecs[k].exp_d));
      chk($sformatf("vec%0d_busy_mid", k), 32'(busy_mid), 32'h1);
      chk($sformatf("vec%0d_busy_end", k), 32'(busy), 32'h0);
    end

    // Back-to-back: CS high for one SCLK period between frames.
    eshape = 1'b0;
    v0 = valid_cnt; e0 = err_cnt;
    got_q.delete();
    frame(32'h0001, 16, 1'b0);
    tick(2);
    frame(32'hFFFF, 16, 1'b0);
    tick(10);
    chk("b2b_valid", 32'(valid_cnt - v0), 32'd2);
    chk("b2b_ferr", 32'(err_cnt - e0), 32'd0);
    chk("b2b_first", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'h0001);
    chk("b2b_second", (got_q.size() > 1) ? 32'(got_q[1]) : 32'hDEAD, 32'hFFFF);

    // Reset after 7 bits, released with CS still low.
    v0 = valid_cnt; e0 = err_cnt;
    cs = 1'b0; tick(3);
    bits(32'h3C3C >> 9, 7, 1'b0);
    rst = 1'b1; #2;
    chk("rst_data_now", 32'(data), 32'h0);
    chk("rst_busy_now", 32'(busy), 32'h0);
    tick(2);
    rst = 1'b0;
    bits(32'h3C3C & 32'h1FF, 9, 1'b0);
    tick(2);
    cs = 1'b1; tick(10);
    chk("rst_valid", 32'(valid_cnt - v0), 32'd0);
    chk("rst_ferr", 32'(err_cnt - e0), 32'd0);
    chk("rst_data_hold", 32'(data), 32'h0);
    frame(32'h1234, 16, 1'b0);
    tick(10);
    chk("post_rst_data", 32'(data), 32'h1234);
    chk("post_rst_valid", 32'(valid_cnt - v0), 32'd1);

    // Disabled at CS fall, enabled mid-frame: frame ignored.
    v0 = valid_cnt; e0 = err_cnt;
    en = 1'b0;
    cs = 1'b0; tick(3);
    en = 1'b1;
    bits(32'hBEEF, 16, 1'b0);
    chk("dis_busy_mid", 32'(busy_mid), 32'h0);
    tick(2);
    cs = 1'b1; tick(10);
    chk("dis_valid", 32'(valid_cnt - v0), 32'd0);
    chk("dis_ferr", 32'(err_cnt - e0), 32'd0);
    chk("dis_data", 32'(data), 32'h1234);
    frame(32'h5A5A, 16, 1'b0);
    tick(10);
    chk("en_data", 32'(data), 32'h5A5A);
    chk("en_valid", 32'(valid_cnt - v0), 32'd1);

    chk("valid_ferr_overlap", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
